// File: rtl/lr1_sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// lr1_sw_debounce_pkg
//   Shared constants for the LR1 switch front end.
//   LR1_SW_W        : number of slide switches on the board
//   LR1_DEB_CNT     : debounce stability window in clock cycles (10 ms @ 100 MHz)
//   LR1_DEB_CNT_SIM : short window used for simulation
// -----------------------------------------------------------------------------
package lr1_sw_debounce_pkg;

  localparam int LR1_SW_W        = 12;
  localparam int LR1_DEB_CNT     = 1000000;
  localparam int LR1_DEB_CNT_SIM = 4;

endpackage

// File: rtl/lr1_debounce_bit.sv
// -----------------------------------------------------------------------------
// lr1_debounce_bit
//   One switch bit: 2-flop synchroniser, stability counter and change strobe.
//   A new synchronised level is accepted only after it has differed from the
//   current debounced level on STABLE_CNT consecutive edges.
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active-high
//   sw_raw  in   asynchronous switch pin
//   sw      out  debounced level
//   sw_chg  out  one-cycle pulse on the cycle sw changes
//   pend    out  synchronised level differs from sw (registered inputs only)
// -----------------------------------------------------------------------------
module lr1_debounce_bit
  import lr1_sw_debounce_pkg::*;
#(
  parameter int STABLE_CNT = LR1_DEB_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw,
  output logic sw_chg,
  output logic pend
);

  localparam int              CNT_W    = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             mis;

  assign mis  = sync2 ^ sw;
  assign pend = mis;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and the
  // sensitivity list holds only the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sw     <= 1'b0;
      sw_chg <= 1'b0;
      cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // sync2 <= sync1 then forms a true two-stage chain.
      sync1  <= sw_raw;
      sync2  <= sync1;
      sw_chg <= 1'b0;
      if (!mis) begin
        // Level agrees again: glitch rejected, no partial credit kept.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw     <= sync2;
        sw_chg <= 1'b1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lr1_sw_debounce.sv
// -----------------------------------------------------------------------------
// lr1_sw_debounce
//   Conditions the raw LR1 slide switches into clean levels for LR1_TOP.SW.
//   Each bit is synchronised, debounced and strobed independently.
// Ports
//   CLK        in   1      system clock, rising edge
//   RST        in   1      synchronous reset, active-high
//   SW_RAW     in   WIDTH  asynchronous switch pins
//   SW         out  WIDTH  debounced switch levels
//   SW_CHG     out  WIDTH  one-cycle pulse per bit when SW[i] changes
//   SW_STABLE  out  1      high when no bit has a pending level
// -----------------------------------------------------------------------------
module lr1_sw_debounce
  import lr1_sw_debounce_pkg::*;
#(
  parameter int WIDTH      = LR1_SW_W,
  parameter int STABLE_CNT = LR1_DEB_CNT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_CHG,
  output logic             SW_STABLE
);

  logic [WIDTH-1:0] pend;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lr1_debounce_bit #(
      .STABLE_CNT (STABLE_CNT)
    ) u_bit (
      .clk    (CLK),
      .rst    (RST),
      .sw_raw (SW_RAW[i]),
      .sw     (SW[i]),
      .sw_chg (SW_CHG[i]),
      .pend   (pend[i])
    );
  end

  // Derived from registers only, so no path from SW_RAW.
  assign SW_STABLE = ~|pend;

endmodule

// File: tb/tb_lr1_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_lr1_sw_debounce
//   Self-checking bench for lr1_sw_debounce with a short debounce window.
//   A reference model tracks the raw input history and, per bit, the length
//   of the current run of edges on which the synchronised input disagrees
//   with the debounced level; a run reaching the window length is accepted.
// -----------------------------------------------------------------------------
module tb_lr1_sw_debounce;
  import lr1_sw_debounce_pkg::*;

  localparam int W = LR1_SW_W;
  localparam int N = LR1_DEB_CNT_SIM;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw;
  logic [W-1:0] sw_chg;
  logic         sw_stable;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_hist0, m_hist1;  // raw value seen at the last / previous edge
  logic [W-1:0] m_sw, m_chg;
  int           m_run [W];

  always #5 clk = ~clk;

  lr1_sw_debounce #(
    .WIDTH      (W),
    .STABLE_CNT (N)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .SW_RAW    (sw_raw),
    .SW        (sw),
    .SW_CHG    (sw_chg),
    .SW_STABLE (sw_stable)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge: drive inputs, advance the model, compare all outputs.
  task automatic tick(input logic r, input logic [W-1:0] raw);
    logic [W-1:0] s2;
    @(negedge clk);
    rst    = r;
    sw_raw = raw;
    @(posedge clk);
    if (r) begin
      m_hist0 = '0;
      m_hist1 = '0;
      m_sw    = '0;
      m_chg   = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      s2    = m_hist1;  // synchronised value is the raw level from two edges back
      m_chg = '0;
      for (int i = 0; i < W; i++) begin
        if (s2[i] != m_sw[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            m_sw[i]  = s2[i];
            m_chg[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_hist1 = m_hist0;
      m_hist0 = raw;
    end
    #1;
    check("sw", 32'(sw), 32'(m_sw));
    check("sw_chg", 32'(sw_chg), 32'(m_chg));
    check("sw_stable", 32'(sw_stable), 32'(m_hist1 == m_sw));
  endtask

  // Hold raw for n edges; report first edge index where sw==target and the
  // number of cycles carrying any change strobe.
  task automatic hold(input logic [W-1:0] raw, input logic [W-1:0] target, input int n,
                      output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, raw);
      if (sw_chg != '0) pulses++;
      if (lat < 0 && sw == target) lat = i;
    end
  endtask

  initial begin
    int lat, pulses, first_pulse, total;
    logic [W-1:0] v;

    rst    = 1'b1;
    sw_raw = ALL1;

    // 1. Reset with all switches high, then release
    tick(1'b1, ALL1);
    tick(1'b1, ALL1);
    check("rst_sw", 32'(sw), 32'h0);
    check("rst_chg", 32'(sw_chg), 32'h0);
    check("rst_stable", 32'(sw_stable), 32'h1);
    hold(ALL1, ALL1, 12, lat, pulses);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_pulses", 32'(pulses), 32'd1);

    // 2. 000 -> 111
    tick(1'b1, '0);
    hold(12'h000, 12'h000, 4, lat, pulses);
    hold(12'h111, 12'h111, 10, lat, pulses);
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_pulses", 32'(pulses), 32'd1);

    // 3. Glitch on bit 0 shorter than the window
    hold(12'h000, 12'h000, 1, lat, pulses);
    tick(1'b1, '0);
    hold(12'h001, 12'h001, 3, lat, total);
    hold(12'h000, 12'h001, 10, lat, pulses);
    check("t3_pulses", 32'(pulses + total), 32'd0);
    check("t3_sw", 32'(sw), 32'h0);
    check("t3_stable", 32'(sw_stable), 32'h1);

    // 4. Bounce on bit 11, then settle high
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, ((i / 2) % 2 == 0) ? 12'h800 : 12'h000);
      if (sw_chg[11]) pulses++;
    end
    first_pulse = -1;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 12'h800);
      if (sw_chg[11]) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_first", 32'(first_pulse), 32'd5);

    // 5. Sweep 000..FFF from reset
    tick(1'b1, '0);
    total = 0;
    for (int k = 0; k < 16; k++) begin
      v = W'(k * 12'h111);
      hold(v, v, 100, lat, pulses);
      total += pulses;
      if (k != 0) check($sformatf("t5_lat_%0d", k), 32'(lat), 32'd5);
    end
    check("t5_pulses", 32'(total), 32'd15);

    // 6. Reset in the middle of a pending 000 -> AAA change
    tick(1'b1, '0);
    hold(12'hAAA, 12'hAAA, 3, lat, pulses);
    tick(1'b1, 12'hAAA);
    check("t6_rst_sw", 32'(sw), 32'h0);
    hold(12'hAAA, 12'hAAA, 10, lat, pulses);
    check("t6_latency", 32'(lat), 32'd5);
    check("t6_pulses", 32'(pulses), 32'd1);

    // Random phase: random levels with random hold times, rare resets
    for (int n = 0; n < 400; n++) begin
      v = W'($urandom);
      if ($urandom_range(0, 3) == 0) v = sw ^ W'(1 << $urandom_range(0, W - 1));
      for (int j = 0; j < int'($urandom_range(1, 8)); j++)
        tick(($urandom_range(0, 99) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
